// File: rtl/wb_xbar_pkg.sv
// Shared types and default address map for the Wishbone peripheral crossbar.
package wb_xbar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        RESP_ACK,
        RESP_ERR,
        RESP_RTY,
        ERR
    } xbar_state_e;

    localparam int ERR_CNT_W = 8;
    localparam int TO_CNT_W  = 16;

    localparam logic [31:0] SPI1_BASE   = 32'h2000_0000;
    localparam logic [31:0] SPI2_BASE   = 32'h2000_0100;
    localparam logic [31:0] I2C_BASE    = 32'h2000_0200;
    localparam logic [31:0] UART_BASE   = 32'h2000_0300;
    localparam logic [31:0] PERIPH_MASK = 32'hFFFF_FF00;

    localparam logic [127:0] DEF_SLV_BASE = {UART_BASE, I2C_BASE, SPI2_BASE, SPI1_BASE};
    localparam logic [127:0] DEF_SLV_MASK = {4{PERIPH_MASK}};

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational priority address matcher; the lowest matching slave index wins.
module wb_addr_decoder #(
    parameter int N_SLV = 4,
    parameter int AW    = 32,
    parameter int IW    = 2,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = '0
) (
    input  logic [AW-1:0] adr_i,
    output logic          hit_o,
    output logic [IW-1:0] idx_o
);

    // Walk from the top so the lowest index is the last (winning) assignment.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((adr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_periph_xbar.sv
// Single-master, N-slave Wishbone classic interconnect with registered decode,
// bus timeout, unmapped-address error response and sticky error capture.
module wb_periph_xbar
    import wb_xbar_pkg::*;
#(
    parameter int N_SLV  = 4,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int TO_CYC = 255
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst,
    input  logic [AW-1:0]             m_adr_i,
    input  logic [DW-1:0]             m_dat_i,
    input  logic [DW/8-1:0]           m_sel_i,
    input  logic                      m_we_i,
    input  logic                      m_cyc_i,
    input  logic                      m_stb_i,
    output logic [DW-1:0]             m_dat_o,
    output logic                      m_ack_o,
    output logic                      m_err_o,
    output logic                      m_rty_o,
    output logic [N_SLV*AW-1:0]       s_adr_o,
    output logic [N_SLV*DW-1:0]       s_dat_o,
    output logic [N_SLV*(DW/8)-1:0]   s_sel_o,
    output logic [N_SLV-1:0]          s_we_o,
    output logic [N_SLV-1:0]          s_cyc_o,
    output logic [N_SLV-1:0]          s_stb_o,
    input  logic [N_SLV*DW-1:0]       s_dat_i,
    input  logic [N_SLV-1:0]          s_ack_i,
    input  logic [N_SLV-1:0]          s_err_i,
    input  logic [N_SLV-1:0]          s_rty_i,
    output logic                      err_flag_o,
    output logic [AW-1:0]             err_adr_o,
    output logic [ERR_CNT_W-1:0]      err_cnt_o
);

    localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    xbar_state_e            state_q, state_d;
    logic [AW-1:0]          adr_q, adr_d;
    logic [DW-1:0]          wdat_q, wdat_d;
    logic [DW/8-1:0]        sel_q, sel_d;
    logic                   we_q, we_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DW-1:0]          rdat_q, rdat_d;
    logic [TO_CNT_W-1:0]    cnt_q, cnt_d;
    logic                   err_flag_q, err_flag_d;
    logic [AW-1:0]          err_adr_q, err_adr_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                   dec_hit;
    logic [IW-1:0]          dec_idx;
    logic [N_SLV-1:0]       slv_onehot;

    wb_addr_decoder #(
        .N_SLV    (N_SLV),
        .AW       (AW),
        .IW       (IW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .adr_i (m_adr_i),
        .hit_o (dec_hit),
        .idx_o (dec_idx)
    );

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        idx_d      = idx_q;
        rdat_d     = rdat_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        err_adr_d  = err_adr_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    adr_d   = m_adr_i;
                    wdat_d  = m_dat_i;
                    sel_d   = m_sel_i;
                    we_d    = m_we_i;
                    idx_d   = dec_idx;
                    cnt_d   = '0;
                    state_d = dec_hit ? ACTIVE : ERR;
                end
            end
            ACTIVE: begin
                cnt_d = cnt_q + 1'b1;
                // A master abort wins over any slave response in the same cycle.
                if (!m_cyc_i) begin
                    state_d = IDLE;
                end else if (s_ack_i[idx_q]) begin
                    rdat_d  = s_dat_i[idx_q*DW +: DW];
                    state_d = RESP_ACK;
                end else if (s_err_i[idx_q]) begin
                    state_d = RESP_ERR;
                end else if (s_rty_i[idx_q]) begin
                    state_d = RESP_RTY;
                end else if (cnt_q == TO_CNT_W'(TO_CYC - 1)) begin
                    state_d = ERR;
                end
            end
            RESP_ACK, RESP_ERR, RESP_RTY: begin
                state_d = IDLE;
            end
            ERR: begin
                err_flag_d = 1'b1;
                err_adr_d  = adr_q;
                if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            wdat_q     <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            rdat_q     <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            err_adr_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            rdat_q     <= rdat_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            err_adr_q  <= err_adr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        slv_onehot = '0;
        if (state_q == ACTIVE) begin
            slv_onehot[idx_q] = 1'b1;
        end
    end

    assign s_cyc_o = slv_onehot;
    assign s_stb_o = slv_onehot;
    assign s_we_o  = slv_onehot & {N_SLV{we_q}};
    assign s_adr_o = {N_SLV{adr_q}};
    assign s_dat_o = {N_SLV{wdat_q}};
    assign s_sel_o = {N_SLV{sel_q}};

    assign m_ack_o = (state_q == RESP_ACK);
    assign m_err_o = (state_q == RESP_ERR) || (state_q == ERR);
    assign m_rty_o = (state_q == RESP_RTY);
    assign m_dat_o = (state_q == RESP_ACK && !we_q) ? rdat_q : '0;

    assign err_flag_o = err_flag_q;
    assign err_adr_o  = err_adr_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_wb_periph_xbar.sv
// Directed bench for wb_periph_xbar: cycle-exact checks of decode, responses,
// timeout, abort, reset and error capture.
module tb_wb_periph_xbar;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              wb_clk = 1'b0;
    logic              wb_rst;
    logic [AW-1:0]     m_adr_i;
    logic [DW-1:0]     m_dat_i;
    logic [DW/8-1:0]   m_sel_i;
    logic              m_we_i, m_cyc_i, m_stb_i;
    logic [DW-1:0]     m_dat_o;
    logic              m_ack_o, m_err_o, m_rty_o;
    logic [N*AW-1:0]   s_adr_o;
    logic [N*DW-1:0]   s_dat_o;
    logic [N*DW/8-1:0] s_sel_o;
    logic [N-1:0]      s_we_o, s_cyc_o, s_stb_o;
    logic [N*DW-1:0]   s_dat_i;
    logic [N-1:0]      s_ack_i, s_err_i, s_rty_i;
    logic              err_flag_o;
    logic [AW-1:0]     err_adr_o;
    logic [7:0]        err_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 wb_clk = ~wb_clk;

    wb_periph_xbar #(.TO_CYC(16)) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .m_adr_i    (m_adr_i),
        .m_dat_i    (m_dat_i),
        .m_sel_i    (m_sel_i),
        .m_we_i     (m_we_i),
        .m_cyc_i    (m_cyc_i),
        .m_stb_i    (m_stb_i),
        .m_dat_o    (m_dat_o),
        .m_ack_o    (m_ack_o),
        .m_err_o    (m_err_o),
        .m_rty_o    (m_rty_o),
        .s_adr_o    (s_adr_o),
        .s_dat_o    (s_dat_o),
        .s_sel_o    (s_sel_o),
        .s_we_o     (s_we_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_dat_i    (s_dat_i),
        .s_ack_i    (s_ack_i),
        .s_err_i    (s_err_i),
        .s_rty_i    (s_rty_i),
        .err_flag_o (err_flag_o),
        .err_adr_o  (err_adr_o),
        .err_cnt_o  (err_cnt_o)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; checks and drives happen here.
    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic start_req(input logic [31:0] adr, input logic [31:0] dat, input logic we);
        m_adr_i = adr;
        m_dat_i = dat;
        m_sel_i = 4'hF;
        m_we_i  = we;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
    endtask

    task automatic end_req();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        m_we_i  = 1'b0;
    endtask

    initial begin
        wb_rst  = 1'b1;
        m_adr_i = '0;
        m_dat_i = '0;
        m_sel_i = '0;
        m_we_i  = 1'b0;
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_dat_i = '0;
        s_ack_i = '0;
        s_err_i = '0;
        s_rty_i = '0;
        tick();
        tick();
        check_val("rst_ack", m_ack_o, 0);
        check_val("rst_err", m_err_o, 0);
        check_val("rst_cyc", s_cyc_o, 0);
        check_val("rst_eflag", err_flag_o, 0);
        check_val("rst_ecnt", err_cnt_o, 0);
        wb_rst = 1'b0;

        // Write 0xA5 to slave1, ack one cycle after stb -> m_ack in cycle 3
        start_req(32'h2000_0104, 32'h0000_00A5, 1'b1);
        tick();
        check_val("wr_stb", s_stb_o, 4'b0010);
        check_val("wr_cyc", s_cyc_o, 4'b0010);
        check_val("wr_we", s_we_o, 4'b0010);
        check_val("wr_dat", s_dat_o[DW +: DW], 32'hA5);
        check_val("wr_adr", s_adr_o[AW +: AW], 32'h2000_0104);
        check_val("wr_ack_c1", m_ack_o, 0);
        tick();
        s_ack_i = 4'b0010;
        check_val("wr_ack_c2", m_ack_o, 0);
        tick();
        s_ack_i = '0;
        check_val("wr_ack_c3", m_ack_o, 1);
        check_val("wr_mdat", m_dat_o, 0);
        check_val("wr_eflag", err_flag_o, 0);
        end_req();
        tick();
        check_val("wr_ack_c4", m_ack_o, 0);

        // Read slave3 with 4 wait cycles; stray ack on slave0 must be ignored
        start_req(32'h2000_0300, 32'h0, 1'b0);
        tick();
        check_val("rd_stb", s_stb_o, 4'b1000);
        check_val("rd_we", s_we_o, 4'b0000);
        for (int c = 1; c <= 4; c++) begin
            check_val("rd_wait_ack", m_ack_o, 0);
            check_val("rd_wait_dat", m_dat_o, 0);
            s_ack_i = (c == 2) ? 4'b0001 : 4'b0000;
            tick();
        end
        s_ack_i = 4'b1000;
        s_dat_i = {32'h0000_0042, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        check_val("rd_c5_ack", m_ack_o, 0);
        tick();
        s_ack_i = '0;
        s_dat_i = '0;
        check_val("rd_c6_ack", m_ack_o, 1);
        check_val("rd_c6_dat", m_dat_o, 32'h42);
        end_req();
        tick();
        check_val("rd_c7_dat", m_dat_o, 0);
        check_val("rd_c7_ack", m_ack_o, 0);

        // Unmapped access
        start_req(32'h3000_0000, 32'h0, 1'b0);
        tick();
        check_val("um_stb", s_stb_o, 0);
        check_val("um_merr", m_err_o, 1);
        end_req();
        tick();
        check_val("um_merr_off", m_err_o, 0);
        check_val("um_eadr", err_adr_o, 32'h3000_0000);
        check_val("um_ecnt", err_cnt_o, 1);
        check_val("um_eflag", err_flag_o, 1);

        // Slave2 silent -> timeout after 16 ACTIVE cycles
        start_req(32'h2000_0208, 32'h0, 1'b0);
        tick();
        for (int c = 1; c <= 16; c++) begin
            check_val("to_stb", s_stb_o, 4'b0100);
            check_val("to_merr_early", m_err_o, 0);
            tick();
        end
        check_val("to_stb_off", s_stb_o, 0);
        check_val("to_merr", m_err_o, 1);
        end_req();
        tick();
        check_val("to_ecnt", err_cnt_o, 2);
        check_val("to_eadr", err_adr_o, 32'h2000_0208);
        check_val("to_eflag", err_flag_o, 1);

        // Zero-wait slave0 write after the timeout
        start_req(32'h2000_0010, 32'h1234_5678, 1'b1);
        tick();
        check_val("s0_stb", s_stb_o, 4'b0001);
        s_ack_i = 4'b0001;
        tick();
        s_ack_i = '0;
        check_val("s0_ack", m_ack_o, 1);
        check_val("s0_err", m_err_o, 0);
        end_req();
        tick();

        // Retry from slave1
        start_req(32'h2000_0100, 32'h0, 1'b0);
        tick();
        s_rty_i = 4'b0010;
        tick();
        s_rty_i = '0;
        check_val("rty_rty", m_rty_o, 1);
        check_val("rty_ack", m_ack_o, 0);
        end_req();
        tick();
        check_val("rty_off", m_rty_o, 0);

        // Master abort in the 2nd ACTIVE cycle
        start_req(32'h2000_0100, 32'h0, 1'b0);
        tick();
        tick();
        check_val("ab_stb_c2", s_stb_o, 4'b0010);
        end_req();
        tick();
        check_val("ab_stb", s_stb_o, 0);
        check_val("ab_cyc", s_cyc_o, 0);
        check_val("ab_ack", m_ack_o, 0);
        check_val("ab_err", m_err_o, 0);
        tick();
        check_val("ab_ack2", m_ack_o, 0);
        check_val("ab_err2", m_err_o, 0);
        check_val("ab_ecnt", err_cnt_o, 2);

        // Reset asserted mid-ACTIVE
        start_req(32'h2000_0000, 32'hFFFF_FFFF, 1'b1);
        tick();
        check_val("mr_stb_pre", s_stb_o, 4'b0001);
        wb_rst = 1'b1;
        tick();
        wb_rst = 1'b0;
        end_req();
        check_val("mr_stb", s_stb_o, 0);
        check_val("mr_we", s_we_o, 0);
        check_val("mr_adr", s_adr_o, 0);
        check_val("mr_eflag", err_flag_o, 0);
        check_val("mr_ecnt", err_cnt_o, 0);
        check_val("mr_eadr", err_adr_o, 0);
        tick();

        // 300 unmapped accesses -> saturating count
        for (int i = 0; i < 300; i++) begin
            start_req(32'h3000_0000 | i, 32'h0, 1'b0);
            tick();
            end_req();
            tick();
        end
        check_val("sat_ecnt", err_cnt_o, 255);
        check_val("sat_eadr", err_adr_o, 32'h3000_012B);

        // Simultaneous ack and err from slave0 -> ack only
        start_req(32'h2000_0000, 32'h0, 1'b0);
        tick();
        s_ack_i = 4'b0001;
        s_err_i = 4'b0001;
        s_dat_i = {96'h0, 32'hDEAD_BEEF};
        tick();
        s_ack_i = '0;
        s_err_i = '0;
        s_dat_i = '0;
        check_val("ae_ack", m_ack_o, 1);
        check_val("ae_err", m_err_o, 0);
        check_val("ae_dat", m_dat_o, 32'hDEAD_BEEF);
        end_req();
        tick();
        check_val("ae_ecnt", err_cnt_o, 255);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_periph_xbar.md
Name: wb_periph_xbar

Overview:
- Parametrised single-master, N-slave Wishbone classic peripheral interconnect.
- Next-generation replacement for the fixed 4-slave peripheral interconnect (SPI x2, I2C, UART).
- Adds a parametrised address map, a registered decode stage, a bus-timeout watchdog, error responses for unmapped addresses, and sticky error capture registers.
- Sits between the core's IO Wishbone port and all peripheral slaves.

Parameters:
- N_SLV, 4, number of slave ports (1..16).
- AW, 32, address width.
- DW, 32, data width.
- SLV_BASE, {32'h2000_0300,32'h2000_0200,32'h2000_0100,32'h2000_0000}, packed N_SLV*AW vector; slave i base is at [i*AW +: AW].
- SLV_MASK, {4{32'hFFFF_FF00}}, packed N_SLV*AW vector; slave i matches when (adr & mask_i) == base_i.
- TO_CYC, 255, cycles without a slave response before timeout (1..65535).

Ports:
- wb_clk  in  1  clock.
- wb_rst  in  1  synchronous active-high reset.
- m_adr_i  in  AW  master address.
- m_dat_i  in  DW  master write data.
- m_sel_i  in  DW/8  byte selects.
- m_we_i  in  1  write enable.
- m_cyc_i  in  1  master cycle.
- m_stb_i  in  1  master strobe.
- m_dat_o  out  DW  read data.
- m_ack_o  out  1  acknowledge.
- m_err_o  out  1  error.
- m_rty_o  out  1  retry.
- s_adr_o  out  N_SLV*AW  per-slave address (broadcast).
- s_dat_o  out  N_SLV*DW  per-slave write data (broadcast).
- s_sel_o  out  N_SLV*DW/8  per-slave byte selects (broadcast).
- s_we_o  out  N_SLV  per-slave write enable.
- s_cyc_o  out  N_SLV  one-hot cycle.
- s_stb_o  out  N_SLV  one-hot strobe.
- s_dat_i  in  N_SLV*DW  per-slave read data.
- s_ack_i  in  N_SLV  per-slave ack.
- s_err_i  in  N_SLV  per-slave err.
- s_rty_i  in  N_SLV  per-slave rty.
- err_flag_o  out  1  sticky: unmapped access or timeout seen.
- err_adr_o  out  AW  address of the most recent failing access.
- err_cnt_o  out  8  saturating error count.

Behaviour:
- Reset (synchronous, wb_rst high at a wb_clk edge): state=IDLE.
  - All m_*_o = 0.
  - s_cyc_o = s_stb_o = s_we_o = 0.
  - err_flag_o = 0, err_adr_o = 0, err_cnt_o = 0, timeout counter = 0.
- Registered slave bus: adr/dat/sel are latched on decode and held stable for the whole transaction.
- FSM states:
  - IDLE: on m_cyc_i & m_stb_i, latch adr/dat/sel/we and evaluate the decoder.
    - Match found: go to ACTIVE.
    - No match: go to ERR.
  - ACTIVE: drive s_cyc_o[sel] = s_stb_o[sel] = 1 for the matched index only; the counter increments each cycle.
    - s_ack_i[sel]: latch s_dat_i[sel] and go to RESP_ACK.
    - s_err_i[sel]: go to RESP_ERR.
    - s_rty_i[sel]: go to RESP_RTY.
    - Priority when several assert together: ack > err > rty.
    - counter == TO_CYC-1 with no response: drop slave strobes and go to ERR (timeout).
    - m_cyc_i == 0 (master abort): clear slave cyc/stb at the next edge, go to IDLE, no master response, no error logged.
  - RESP_ACK / RESP_ERR / RESP_RTY: assert the corresponding m_*_o for exactly one cycle, then go to IDLE. m_dat_o holds the latched data and is 0 except after a read ack.
  - ERR: m_err_o = 1 for one cycle; err_flag_o <= 1; err_adr_o <= latched adr; err_cnt_o increments, saturating at 255; then IDLE.
- Latency:
  - Request sampled at edge 0; slave strobe visible in cycle 1.
  - Slave ack at edge k gives m_ack_o in cycle k+1.
  - Unmapped access gives m_err_o in cycle 1.
  - A zero-wait slave gives a 3-cycle round trip.
- Back-to-back: IDLE accepts a new request in the cycle immediately after a response cycle. The master must deassert stb on the edge where it sees ack/err.
- Decode:
  - Lowest-index match wins when windows overlap.
  - A mask of all zero matches everything (catch-all slave).
- A slave response on a non-selected index is ignored.
- Timeout counter resets on every entry to ACTIVE.
- err_flag_o and err_cnt_o clear only on reset.

Decomposition:
- Package wb_xbar_pkg:
  - state enum {IDLE, ACTIVE, RESP_ACK, RESP_ERR, RESP_RTY, ERR}.
  - Default peripheral base/mask constants (SPI1 0x2000_0000, SPI2 0x2000_0100, I2C 0x2000_0200, UART 0x2000_0300).
  - ERR_CNT_W = 8.
- Sub-module wb_addr_decoder: purely combinational priority matcher; outputs hit and a $clog2(N_SLV) index.

Test Plan:
- Write 0xA5 to 0x2000_0104, slave1 acks one cycle after its stb -> only s_stb_o[1] high, s_dat_o[1] = 0xA5, m_ack_o high at cycle 3 for one cycle, err_flag_o = 0.
- Read 0x2000_0300, slave3 returns 0x0000_0042 after 4 wait cycles -> m_dat_o = 0x42 with m_ack_o at cycle 6; m_dat_o = 0 in all other cycles.
- Access 0x3000_0000 (unmapped) -> no s_stb_o asserted, m_err_o pulses at cycle 1, err_adr_o = 0x3000_0000, err_cnt_o = 1.
- Slave2 never responds, TO_CYC = 16 -> s_stb_o[2] deasserts and m_err_o pulses after 16 ACTIVE cycles, err_flag_o = 1; a following access to slave0 completes normally.
- Master drops m_cyc_i in the 2nd ACTIVE cycle -> slave cyc/stb cleared at the next edge, no m_ack_o/m_err_o, err_cnt_o unchanged; wb_rst asserted mid-ACTIVE -> all outputs 0 at the next cycle.
- 300 unmapped accesses back-to-back -> err_cnt_o saturates at 255; slave0 asserts ack and err in the same cycle -> m_ack_o only.
